tft_video_capture: RTL and testbench
====================================

Name: tft_video_capture

Overview:
- Front end of the TFT path: sits directly upstream of the parallel-TFT writer.
- Takes the core's raw 3:3:3 RGB video with separate hsync/vsync and produces a pixel-synchronous stream:
  - 5:6:5 colour
  - 10-bit hc/vc coordinates, with (0,0) at the first active pixel
- The downstream writer consumes r/g/b/hc/vc directly and compares hc/vc against fixed constants, so coordinates must be exact and glitch-free.

Parameters:
- H_SKIP, 10'd48: pixels from hsync leading edge to first active pixel.
- V_SKIP, 10'd33: lines from vsync leading edge to first active line.
- H_ACTIVE, 10'd640: active pixels per line.
- V_ACTIVE, 10'd440: active lines per frame (400 picture plus 40 fill).
- SYNC_NEG, 1'b1: sync leading edge is falling (1) or rising (0); ignored when SYNC_POL_AUTO_EN is defined.

Ports:
- clk  in  1  system clock (same domain as the TFT writer).
- rst_n  in  1  asynchronous active-low reset.
- pix_ce  in  1  pixel clock enable; all pixel state advances only when high.
- r_in  in  3  red from core.
- g_in  in  3  green from core.
- b_in  in  3  blue from core.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- r  out  5  red, 5-bit.
- g  out  6  green, 6-bit.
- b  out  5  blue, 5-bit.
- hc  out  10  horizontal coordinate.
- vc  out  10  vertical coordinate.
- frame_start  out  1  one-clk pulse at vsync leading edge.
- locked  out  1  frame line count stable.

Behaviour:
- Reset: asynchronous assert, active-low; clock is clk.
  - All outputs 0: r, g, b, hc, vc, frame_start, locked.
  - Sync history registers reset to the inactive level.
  - Internal line counter and previous-frame count reset to 0.
- Sync sampling:
  - hsync_in/vsync_in are registered on each pix_ce.
  - Leading edge = registered value differs from the prior sample, in the active direction.
- Horizontal counter, on a pix_ce cycle:
  - hsync leading edge: hc <= 10'd0 - H_SKIP (mod 1024).
  - Otherwise: hc <= hc + 1, saturating at 10'h3FF (no wrap).
- Vertical counter, on an hsync leading edge:
  - vsync leading edge in the same pix_ce cycle: vc <= 10'd0 - V_SKIP; vsync has priority.
  - Otherwise: vc <= vc + 1, saturating at 10'h3FF.
- Colour expansion, registered on pix_ce, 1-cycle latency, aligned with hc/vc of the same sample:
  - r = {r_in, r_in[2:1]}
  - g = {g_in, g_in}
  - b = {b_in, b_in[2:1]}
- Blanking: when hc >= H_ACTIVE or vc >= V_ACTIVE (unsigned compare), r/g/b are 0.
  - Wrapped pre-active values, e.g. 10'd976, are therefore blank.
- Hold: when pix_ce is low, every output holds its value, except frame_start, which is 0.
- frame_start: high for exactly one clk, on the pix_ce cycle where the vsync leading edge is detected.
- Lock detection:
  - An internal 10-bit line counter counts hsync leading edges, resetting at each vsync leading edge.
  - At each vsync edge, the count is compared with the previous frame's count.
  - locked <= (equal and nonzero).
  - The previous-frame count is then updated.
  - Any mismatch clears locked at that vsync edge.
- Reset mid-frame: counters restart from 0 and locked drops.
  - Outputs are valid again only from the next vsync edge.
  - locked reasserts after 2 further matching frames.

Optional Feature:
- Macro: SYNC_POL_AUTO_EN.
- Defined:
  - Per sync, a 10-bit counter measures the high-phase and low-phase lengths (in pix_ce cycles, saturating).
  - The shorter phase is treated as active; polarity is re-evaluated at every transition.
  - SYNC_NEG is ignored.
  - Until both phases have been measured once after reset, no leading edges are reported.
- Undefined: polarity is fixed by SYNC_NEG and the measurement logic is absent.

Decomposition:
- Shared package holds:
  - colour expansion functions (3->5, 3->6)
  - default timing constants: 48, 33, 640, 440
  - the 10-bit coordinate width constant
- One sub-module, sync_edge_detect, instantiated twice (hsync and vsync). It contains:
  - the registered sample
  - the leading-edge pulse
  - under SYNC_POL_AUTO_EN, the polarity measurement

Test Plan:
- Reset check: drive rst_n=0 mid-line -> all outputs 0 asynchronously; after release, counters remain free until the first vsync edge.
- Coordinate origin: SYNC_NEG=1; hsync falls, pix_ce every clk -> hc reads 976 one cycle later, then reaches 0 after 48 pixels; with vsync falling on the same cycle, vc=0 after 33 lines.
- Colour expansion: r_in=3'b101, g_in=3'b011, b_in=3'b111 at hc=5, vc=5 -> r=5'b10110, g=6'b011011, b=5'b11111 one pix_ce later; the same input at hc=640 -> r/g/b=0.
- pix_ce gating: pix_ce toggling 1-of-2 -> hc advances once per two clks; frame_start is exactly 1 clk wide.
- Lock: two frames of 525 lines -> locked=1 at the second vsync edge; a third frame of 524 lines -> locked=0 at its vsync edge.
- Saturation: hsync withheld for 1200 pixels -> hc holds at 1023 and never wraps to 0.

Source files
------------

// File: rtl/tft_video_capture_pkg.sv
// rtl/tft_video_capture_pkg.sv - shared constants and colour expansion helpers for the TFT capture front end
package tft_video_capture_pkg;

    localparam int COORD_W = 10;
    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    localparam logic [COORD_W-1:0] H_SKIP_DEF   = 10'd48;
    localparam logic [COORD_W-1:0] V_SKIP_DEF   = 10'd33;
    localparam logic [COORD_W-1:0] H_ACTIVE_DEF = 10'd640;
    localparam logic [COORD_W-1:0] V_ACTIVE_DEF = 10'd440;

    // Replicate MSBs into the new LSBs so full-scale input maps to full-scale output.
    function automatic logic [4:0] expand3to5(input logic [2:0] c);
        return {c, c[2:1]};
    endfunction

    function automatic logic [5:0] expand3to6(input logic [2:0] c);
        return {c, c};
    endfunction

endpackage

// File: rtl/tft_video_capture_sync_edge_detect.sv
// rtl/tft_video_capture_sync_edge_detect.sv - sync sampler and leading-edge pulse; SYNC_POL_AUTO_EN selects measured polarity
module sync_edge_detect #(
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pix_ce,
    input  logic sync_in,
    output logic lead_edge
);

`ifdef SYNC_POL_AUTO_EN
    logic       sync_q, sync_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] hi_len_q, hi_len_d;
    logic [9:0] lo_len_q, lo_len_d;
    logic       hi_seen_q, hi_seen_d;
    logic       lo_seen_q, lo_seen_d;
    logic       toggled;

    // The shorter of the two measured phases is taken to be the sync pulse.
    always_comb begin
        sync_d    = sync_q;
        cnt_d     = cnt_q;
        hi_len_d  = hi_len_q;
        lo_len_d  = lo_len_q;
        hi_seen_d = hi_seen_q;
        lo_seen_d = lo_seen_q;
        toggled   = pix_ce && (sync_in != sync_q);
        if (pix_ce) begin
            sync_d = sync_in;
            if (toggled) begin
                cnt_d = 10'd1;
                if (sync_q) begin
                    hi_len_d  = cnt_q;
                    hi_seen_d = 1'b1;
                end else begin
                    lo_len_d  = cnt_q;
                    lo_seen_d = 1'b1;
                end
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 10'd1;
            end
        end
        lead_edge = toggled && hi_seen_d && lo_seen_d && (sync_in == (hi_len_d < lo_len_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 1'b0;
            cnt_q     <= '0;
            hi_len_q  <= '0;
            lo_len_q  <= '0;
            hi_seen_q <= 1'b0;
            lo_seen_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            hi_len_q  <= hi_len_d;
            lo_len_q  <= lo_len_d;
            hi_seen_q <= hi_seen_d;
            lo_seen_q <= lo_seen_d;
        end
    end
`else
    localparam logic IDLE_LVL = SYNC_NEG;

    logic sync_q, sync_d;

    always_comb begin
        sync_d    = pix_ce ? sync_in : sync_q;
        lead_edge = pix_ce && (sync_in != sync_q) && (sync_in != IDLE_LVL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= IDLE_LVL;
        end else begin
            sync_q <= sync_d;
        end
    end
`endif

endmodule

// File: rtl/tft_video_capture.sv
// rtl/tft_video_capture.sv - 3:3:3 RGB + hsync/vsync to 5:6:5 with hc/vc coordinates and lock detect
// Optional macro SYNC_POL_AUTO_EN: measure sync polarity instead of using SYNC_NEG.
module tft_video_capture
    import tft_video_capture_pkg::*;
#(
    parameter logic [COORD_W-1:0] H_SKIP   = H_SKIP_DEF,
    parameter logic [COORD_W-1:0] V_SKIP   = V_SKIP_DEF,
    parameter logic [COORD_W-1:0] H_ACTIVE = H_ACTIVE_DEF,
    parameter logic [COORD_W-1:0] V_ACTIVE = V_ACTIVE_DEF,
    parameter bit                 SYNC_NEG = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    input  logic [2:0]         r_in,
    input  logic [2:0]         g_in,
    input  logic [2:0]         b_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic [4:0]         r,
    output logic [5:0]         g,
    output logic [4:0]         b,
    output logic [COORD_W-1:0] hc,
    output logic [COORD_W-1:0] vc,
    output logic               frame_start,
    output logic               locked
);

    logic hs_edge, vs_edge;

    sync_edge_detect #(.SYNC_NEG(SYNC_NEG)) u_hs_edge (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .sync_in(hsync_in), .lead_edge(hs_edge)
    );

    sync_edge_detect #(.SYNC_NEG(SYNC_NEG)) u_vs_edge (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .sync_in(vsync_in), .lead_edge(vs_edge)
    );

    logic [4:0]         r_q, r_d, b_q, b_d;
    logic [5:0]         g_q, g_d;
    logic [COORD_W-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [COORD_W-1:0] line_cnt_q, line_cnt_d, prev_cnt_q, prev_cnt_d;
    logic               hpre_q, hpre_d, vpre_q, vpre_d;
    logic               frame_start_q, frame_start_d;
    logic               locked_q, locked_d;
    logic               active;

    // hpre/vpre mark the wrapped pre-active span, which must roll through 1023 to 0
    // instead of saturating there.
    always_comb begin
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        hc_d          = hc_q;
        vc_d          = vc_q;
        hpre_d        = hpre_q;
        vpre_d        = vpre_q;
        line_cnt_d    = line_cnt_q;
        prev_cnt_d    = prev_cnt_q;
        locked_d      = locked_q;
        frame_start_d = 1'b0;
        active        = 1'b0;
        if (pix_ce) begin
            frame_start_d = vs_edge;
            if (hs_edge) begin
                hc_d   = '0 - H_SKIP;
                hpre_d = (H_SKIP != '0);
            end else if (hpre_q || hc_q != COORD_MAX) begin
                hc_d = hc_q + 1'b1;
                if (hc_q == COORD_MAX) hpre_d = 1'b0;
            end

            if (hs_edge) begin
                if (vs_edge) begin
                    vc_d   = '0 - V_SKIP;
                    vpre_d = (V_SKIP != '0);
                end else if (vpre_q || vc_q != COORD_MAX) begin
                    vc_d = vc_q + 1'b1;
                    if (vc_q == COORD_MAX) vpre_d = 1'b0;
                end
            end

            if (vs_edge) begin
                locked_d   = (line_cnt_q == prev_cnt_q) && (line_cnt_q != '0);
                prev_cnt_d = line_cnt_q;
                line_cnt_d = {{(COORD_W-1){1'b0}}, hs_edge};
            end else if (hs_edge && line_cnt_q != COORD_MAX) begin
                line_cnt_d = line_cnt_q + 1'b1;
            end

            active = (hc_d < H_ACTIVE) && (vc_d < V_ACTIVE);
            r_d    = active ? expand3to5(r_in) : '0;
            g_d    = active ? expand3to6(g_in) : '0;
            b_d    = active ? expand3to5(b_in) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            hpre_q        <= 1'b0;
            vpre_q        <= 1'b0;
            line_cnt_q    <= '0;
            prev_cnt_q    <= '0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hpre_q        <= hpre_d;
            vpre_q        <= vpre_d;
            line_cnt_q    <= line_cnt_d;
            prev_cnt_q    <= prev_cnt_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign hc          = hc_q;
    assign vc          = vc_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_tft_video_capture.sv
// tb/tb_tft_video_capture.sv - randomized scoreboard bench for tft_video_capture against a position-based model
module tb_tft_video_capture;

    logic       clk = 1'b0;
    logic       rst_n, pix_ce, hsync_in, vsync_in;
    logic [2:0] r_in, g_in, b_in;
    logic [4:0] r, b;
    logic [5:0] g;
    logic [9:0] hc, vc;
    logic       frame_start, locked;

    always #5 clk = ~clk;

    tft_video_capture dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r(r), .g(g), .b(b), .hc(hc), .vc(vc),
        .frame_start(frame_start), .locked(locked)
    );

    typedef struct {
        int r; int g; int b; int hc; int vc; int fs; int lk;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: position relative to the first active pixel/line, negative in the skip region.
    int m_hpos, m_vpos, m_lines, m_prev_lines;
    int m_r, m_g, m_b, m_fs, m_lk;
    bit m_hs_prev, m_vs_prev;
    bit alt_ce = 1'b0;

    function automatic int coord(input int p);
        if (p < 0)    return p + 1024;
        if (p > 1023) return 1023;
        return p;
    endfunction

    task automatic apply(input bit rn, input bit ce, input bit hs, input bit vs);
        logic [2:0] rr, gg, bb;
        bit he, ve;
        exp_t e;
        rr = 3'($urandom_range(0, 7));
        gg = 3'($urandom_range(0, 7));
        bb = 3'($urandom_range(0, 7));
        rst_n = rn; pix_ce = ce; hsync_in = hs; vsync_in = vs;
        r_in = rr; g_in = gg; b_in = bb;
        if (!rn) begin
            m_hpos = 0; m_vpos = 0; m_lines = 0; m_prev_lines = 0;
            m_r = 0; m_g = 0; m_b = 0; m_fs = 0; m_lk = 0;
            m_hs_prev = 1'b1; m_vs_prev = 1'b1;
        end else if (ce) begin
            he = m_hs_prev && !hs;
            ve = m_vs_prev && !vs;
            m_hs_prev = hs;
            m_vs_prev = vs;
            if (he) m_hpos = -48;
            else if (m_hpos < 4000) m_hpos++;
            if (he) begin
                if (ve) m_vpos = -33;
                else if (m_vpos < 4000) m_vpos++;
            end
            if (ve) begin
                m_lk = (m_lines == m_prev_lines && m_lines != 0) ? 1 : 0;
                m_prev_lines = m_lines;
                m_lines = he ? 1 : 0;
            end else if (he && m_lines < 1023) begin
                m_lines++;
            end
            m_fs = ve ? 1 : 0;
            if (coord(m_hpos) < 640 && coord(m_vpos) < 440) begin
                m_r = int'(rr) * 4 + int'(rr) / 2;
                m_g = int'(gg) * 9;
                m_b = int'(bb) * 4 + int'(bb) / 2;
            end else begin
                m_r = 0; m_g = 0; m_b = 0;
            end
        end else begin
            m_fs = 0;
        end
        e.r = m_r; e.g = m_g; e.b = m_b;
        e.hc = coord(m_hpos); e.vc = coord(m_vpos);
        e.fs = m_fs; e.lk = m_lk;
        exp_q.push_back(e);
    endtask

    task automatic next(input bit rn, input bit ce, input bit hs, input bit vs);
        @(negedge clk);
        apply(rn, ce, hs, vs);
    endtask

    function automatic bit pick_ce(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            alt_ce = !alt_ce;
            return alt_ce;
        end
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic drive_frame(input int lines, input int len, input int hs_w, input int vs_lines, input int mode);
        bit ce;
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < len; x++) begin
                do begin
                    ce = pick_ce(mode);
                    next(1'b1, ce, (x < hs_w) ? 1'b0 : 1'b1, (y < vs_lines) ? 1'b0 : 1'b1);
                end while (!ce);
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_underflow t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (int'(r) != e.r || int'(g) != e.g || int'(b) != e.b || int'(hc) != e.hc ||
                int'(vc) != e.vc || int'(frame_start) != e.fs || int'(locked) != e.lk) begin
                miscompares++;
                $display("FAIL outputs t=%0t got r=%0d g=%0d b=%0d hc=%0d vc=%0d fs=%0d lk=%0d exp r=%0d g=%0d b=%0d hc=%0d vc=%0d fs=%0d lk=%0d",
                         $time, r, g, b, hc, vc, frame_start, locked,
                         e.r, e.g, e.b, e.hc, e.vc, e.fs, e.lk);
            end
        end
    end

    initial begin
        apply(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) next(1'b0, 1'b0, 1'b1, 1'b1);

        drive_frame(3, 60, 4, 1, 0);
        drive_frame(1, 30, 4, 0, 0);

        // Asynchronous reset mid-line, observed away from any clock edge.
        next(1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        vectors++;
        if (r != 0 || g != 0 || b != 0 || hc != 0 || vc != 0 || frame_start || locked) begin
            miscompares++;
            $display("FAIL async_reset got r=%0d g=%0d b=%0d hc=%0d vc=%0d fs=%0d lk=%0d exp all 0",
                     r, g, b, hc, vc, frame_start, locked);
        end
        next(1'b0, 1'b1, 1'b1, 1'b1);

        drive_frame(1, 20, 4, 0, 0);
        drive_frame(36, 700, 8, 2, 2);
        drive_frame(4, 100, 8, 0, 1);
        drive_frame(1, 1300, 8, 0, 0);

        drive_frame(525, 16, 2, 2, 0);
        drive_frame(525, 16, 2, 2, 0);
        drive_frame(524, 16, 2, 2, 0);
        drive_frame(2, 16, 2, 2, 0);

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover got %0d entries exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
